// File: rtl/clock_gen_bank.sv
// Bank of NUM_CH independently programmable divided clocks derived from clk.
// Each channel runs a small IDLE/RUN/STOPPING FSM around a half-period down-counter.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | channel parked, clk_out low, counter cleared
//   S_RUN      | counting half-periods, clk_out toggles on terminal count
//   S_STOPPING | enable dropped while high; finishing the high phase
module clock_gen_bank #(
   parameter  int NUM_CH     = 13,
   parameter  int HP_W       = 8,
   parameter  int DEFAULT_HP = 1,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] clk_en,
   input  logic              sync_start,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [HP_W-1:0]   cfg_hp,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] clk_rise,
   output logic [NUM_CH-1:0] busy
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_RUN      = 2'd1,
      S_STOPPING = 2'd2
   } state_t;

   state_t            state_q   [NUM_CH];
   state_t            state_d   [NUM_CH];
   logic [HP_W-1:0]   cnt_q     [NUM_CH];
   logic [HP_W-1:0]   cnt_d     [NUM_CH];
   logic [HP_W-1:0]   hp_shadow [NUM_CH];
   logic [HP_W-1:0]   reload    [NUM_CH];
   logic [NUM_CH-1:0] out_d;
   logic [NUM_CH-1:0] rise_d;
   logic              cfg_ok;

   assign cfg_ok = cfg_wr && (cfg_hp != '0) && (32'(cfg_ch) < NUM_CH);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            hp_shadow[i] <= HP_W'(DEFAULT_HP);
         end
         cfg_err <= 1'b0;
      end else begin
         if (cfg_ok) begin
            hp_shadow[cfg_ch] <= cfg_hp;
         end
         cfg_err <= cfg_wr && !cfg_ok;
      end
   end

   // The counter holds remaining cycles of the current half-period, so a new
   // half-period only takes effect when it is reloaded at the next toggle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = clk_out;
      rise_d  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         reload[i] = hp_shadow[i] - HP_W'(1);
         case (state_q[i])
            S_IDLE: begin
               if (clk_en[i]) begin
                  state_d[i] = S_RUN;
                  cnt_d[i]   = reload[i];
                  out_d[i]   = 1'b0;
               end
            end
            S_RUN, S_STOPPING: begin
               if (sync_start && clk_en[i]) begin
                  state_d[i] = S_RUN;
                  cnt_d[i]   = reload[i];
                  out_d[i]   = 1'b0;
               end else if (clk_en[i]) begin
                  state_d[i] = S_RUN;
                  if (cnt_q[i] == '0) begin
                     cnt_d[i] = reload[i];
                     out_d[i] = !clk_out[i];
                  end else begin
                     cnt_d[i] = cnt_q[i] - HP_W'(1);
                  end
               end else if (!clk_out[i]) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
               end else if (cnt_q[i] == '0) begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                  out_d[i]   = 1'b0;
               end else begin
                  state_d[i] = S_STOPPING;
                  cnt_d[i]   = cnt_q[i] - HP_W'(1);
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
               out_d[i]   = 1'b0;
            end
         endcase
         rise_d[i] = !clk_out[i] && out_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= S_IDLE;
            cnt_q[i]   <= '0;
         end
         clk_out  <= '0;
         clk_rise <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clk_out  <= out_d;
         clk_rise <= rise_d;
      end
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (state_q[i] != S_IDLE);
      end
   end

endmodule

// File: tb/tb_clock_gen_bank.sv
// Directed bench for clock_gen_bank: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clock_gen_bank;

   localparam int NUM_CH = 13;
   localparam int HP_W   = 8;
   localparam int S_OUT  = 0;
   localparam int S_RISE = 1;
   localparam int S_BUSY = 2;
   localparam int S_ERR  = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NUM_CH-1:0] clk_en = '0;
   logic              sync_start = 1'b0;
   logic              cfg_wr = 1'b0;
   logic [3:0]        cfg_ch = '0;
   logic [HP_W-1:0]   cfg_hp = '0;
   logic              cfg_err;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] clk_rise;
   logic [NUM_CH-1:0] busy;

   clock_gen_bank #(.NUM_CH(NUM_CH), .HP_W(HP_W), .DEFAULT_HP(1)) dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .sync_start(sync_start),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_hp(cfg_hp), .cfg_err(cfg_err),
      .clk_out(clk_out), .clk_rise(clk_rise), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int                cyc;
      int                sel;
      logic [NUM_CH-1:0] mask;
      logic [NUM_CH-1:0] val;
      string             name;
   } exp_t;

   exp_t sb_q[$];

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_vec(int dly, int sel, logic [NUM_CH-1:0] mask,
                             logic [NUM_CH-1:0] val, string name);
      exp_t e;
      e.cyc  = cyc + dly;
      e.sel  = sel;
      e.mask = mask;
      e.val  = val;
      e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic expect_ch(int dly, int sel, int ch, logic v, string name);
      logic [NUM_CH-1:0] m;
      m = '0;
      m[ch] = 1'b1;
      expect_vec(dly, sel, m, v ? m : '0, name);
   endtask

   // w[k] is the expected clk_out[ch] after the (k+1)-th upcoming edge.
   task automatic expect_wave(int ch, string w, logic prev0, string name);
      logic p;
      logic b;
      p = prev0;
      for (int k = 0; k < w.len(); k++) begin
         b = (w[k] == "1");
         expect_ch(k + 1, S_OUT, ch, b, name);
         expect_ch(k + 1, S_RISE, ch, b && !p, {name, "_rise"});
         p = b;
      end
   endtask

   function automatic logic [NUM_CH-1:0] pick(int sel);
      case (sel)
         S_OUT:   return clk_out;
         S_RISE:  return clk_rise;
         S_BUSY:  return busy;
         default: return {{(NUM_CH-1){1'b0}}, cfg_err};
      endcase
   endfunction

   always @(negedge clk) begin
      logic [NUM_CH-1:0] act;
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
         if (sb_q[i].cyc <= cyc) begin
            act = pick(sb_q[i].sel);
            n_checks++;
            if (sb_q[i].cyc < cyc) begin
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                        sb_q[i].name, sb_q[i].cyc, cyc);
            end else if ((act & sb_q[i].mask) !== (sb_q[i].val & sb_q[i].mask)) begin
               n_fail++;
               $display("FAIL %s @cycle %0d: got %b, required %b (mask %b)",
                        sb_q[i].name, cyc, act & sb_q[i].mask,
                        sb_q[i].val & sb_q[i].mask, sb_q[i].mask);
            end
            sb_q.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      tick(1);
      expect_vec(1, S_OUT,  '1, '0, "rst_out");
      expect_vec(1, S_RISE, '1, '0, "rst_rise");
      expect_vec(1, S_BUSY, '1, '0, "rst_busy");
      expect_vec(1, S_ERR,  1,  0,  "rst_err");
      tick(1);
      rst = 1'b0;

      // ch0 at default hp=1: clk/2
      clk_en[0] = 1'b1;
      expect_wave(0, "010101", 1'b0, "t1_ch0");
      expect_ch(1, S_BUSY, 0, 1'b1, "t1_busy");
      tick(6);
      clk_en[0] = 1'b0;
      expect_ch(1, S_OUT,  0, 1'b0, "t1_stop_out");
      expect_ch(1, S_BUSY, 0, 1'b0, "t1_stop_busy");
      tick(1);

      // ch3 hp=5, rewritten to hp=2 during the first high phase
      cfg_wr = 1'b1; cfg_ch = 4'd3; cfg_hp = 8'd5;
      expect_vec(1, S_ERR, 1, 0, "t2_cfg_ok");
      tick(1);
      cfg_wr = 1'b0;
      clk_en[3] = 1'b1;
      expect_wave(3, "00000111110011001", 1'b0, "t2_ch3");
      tick(7);
      cfg_wr = 1'b1; cfg_hp = 8'd2;
      tick(1);
      cfg_wr = 1'b0;
      tick(9);

      // drop enable one cycle into a high phase: high completes, then idle
      clk_en[3] = 1'b0;
      expect_ch(1, S_OUT,  3, 1'b1, "t3_hold_high");
      expect_ch(1, S_BUSY, 3, 1'b1, "t3_stopping_busy");
      expect_ch(2, S_OUT,  3, 1'b0, "t3_stop_low");
      expect_ch(2, S_BUSY, 3, 1'b0, "t3_stop_idle");
      tick(2);

      // drop enable during the low phase: idle next cycle
      clk_en[3] = 1'b1;
      expect_ch(1, S_BUSY, 3, 1'b1, "t3b_run");
      tick(1);
      clk_en[3] = 1'b0;
      expect_ch(1, S_BUSY, 3, 1'b0, "t3b_idle");
      expect_ch(1, S_OUT,  3, 1'b0, "t3b_low");
      tick(2);

      // ch1 hp=3, ch2 hp=4, then sync_start on the edge where ch1 would rise
      cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_hp = 8'd3;
      tick(1);
      cfg_ch = 4'd2; cfg_hp = 8'd4;
      tick(1);
      cfg_wr = 1'b0;
      clk_en[2:1] = 2'b11;
      expect_wave(1, "000111000", 1'b0, "t4_ch1");
      expect_wave(2, "000011110", 1'b0, "t4_ch2");
      tick(9);
      sync_start = 1'b1;
      expect_wave(1, "00011", 1'b0, "t4_sync_ch1");
      expect_wave(2, "00001", 1'b0, "t4_sync_ch2");
      expect_vec(1, S_BUSY, 13'b1001, '0, "t4_idle_busy");
      expect_vec(1, S_OUT,  13'b1001, '0, "t4_idle_out");
      tick(1);
      sync_start = 1'b0;
      tick(4);

      // rejected writes: hp=0 and out-of-range channel
      cfg_wr = 1'b1; cfg_ch = 4'd1; cfg_hp = 8'd0;
      expect_vec(1, S_ERR, 1, 1, "t5_err_hp0");
      expect_wave(1, "10001110001", 1'b1, "t5_ch1");
      tick(1);
      cfg_ch = 4'd13; cfg_hp = 8'd7;
      expect_vec(1, S_ERR, 1, 1, "t5_err_ch");
      tick(1);
      cfg_wr = 1'b0;
      expect_vec(1, S_ERR, 1, 0, "t5_err_clear");
      tick(9);

      // reset with all channels running; hp reverts to default
      clk_en = '1;
      tick(7);
      rst = 1'b1;
      expect_vec(1, S_OUT,  '1, '0, "t6_rst_out");
      expect_vec(1, S_RISE, '1, '0, "t6_rst_rise");
      expect_vec(1, S_BUSY, '1, '0, "t6_rst_busy");
      tick(1);
      rst = 1'b0;
      expect_vec(1, S_OUT,  '1, '0, "t6_restart_low");
      expect_vec(1, S_BUSY, '1, '1, "t6_restart_busy");
      expect_vec(2, S_OUT,  '1, '1, "t6_default_hp");
      expect_vec(2, S_RISE, '1, '1, "t6_default_rise");
      tick(3);
      clk_en = '0;
      tick(5);

      foreach (sb_q[i]) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: expectation for cycle %0d never checked", sb_q[i].name, sb_q[i].cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
